sub_bytes_iter: RTL and testbench

Parametrised, time-multiplexed AES SubBytes / InvSubBytes engine for a full state block. A configurable number of S-box lanes processes NUM_BYTES bytes over NUM_BYTES/LANES cycles, trading area for latency. It sits between the AddRoundKey and ShiftRows stages of the encryption and decryption datapaths, with valid/ready handshakes on both sides.

---
 rtl/aes_sbox_pkg.sv | 53 +++++
 rtl/sbox_lane.sv | 29 ++
 rtl/sub_bytes_iter.sv | 116 +++++++++++
 tb/tb_sub_bytes_iter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box tables, byte type, mode encodings and FSM states for the SubBytes engine.
package aes_sbox_pkg;

    typedef logic [7:0] byte_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// Single-byte combinational S-box lookup; the inverse table is built only when SUBBYTES_INV_EN is defined.
module sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [7:0] sel_byte,
    input  logic       mode,
    output logic [7:0] sub_byte
);

`ifdef SUBBYTES_INV_EN
    // Select forward or inverse substitution by mode.
    always_comb begin
        if (mode == MODE_DEC) begin
            sub_byte = SBOX_INV[sel_byte];
        end else begin
            sub_byte = SBOX_FWD[sel_byte];
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;

    // Forward-only build: every byte gets SubBytes.
    always_comb begin
        sub_byte = SBOX_FWD[sel_byte];
    end
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine: LANES S-boxes sweep the block over NUM_BYTES/LANES cycles.
// Define SUBBYTES_INV_EN to build the inverse tables and honour in_mode; otherwise forward only.
module sub_bytes_iter
    import aes_sbox_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int ITERS = NUM_BYTES / LANES;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    if ((NUM_BYTES % LANES) != 0) begin : g_lane_check
        $error("sub_bytes_iter: LANES must divide NUM_BYTES");
    end

    state_e                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [8*NUM_BYTES-1:0] wr_r;
    logic                   mode_r;
    logic [8*NUM_BYTES-1:0] wr_next_s;
    logic                   accept_s;
    logic                   load_mode_s;
    byte_t                  lane_in_s  [LANES];
    byte_t                  lane_out_s [LANES];

`ifdef SUBBYTES_INV_EN
    assign load_mode_s = in_mode;
`else
    logic unused_in_mode_s;
    assign unused_in_mode_s = in_mode;
    assign load_mode_s      = MODE_ENC;
`endif

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_BUSY);
    assign out_data  = wr_r;
    assign out_mode  = mode_r;

    // Lane k reads byte cnt*LANES+k of the working register.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_in_s[k] = wr_r[(int'(cnt_r) * LANES + k) * 8 +: 8];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sbox_lane u_lane (
            .sel_byte (lane_in_s[k]),
            .mode     (mode_r),
            .sub_byte (lane_out_s[k])
        );
    end

    // Write the substituted lane bytes back into their slots, leaving the rest untouched.
    always_comb begin
        wr_next_s = wr_r;
        for (int k = 0; k < LANES; k++) begin
            wr_next_s[(int'(cnt_r) * LANES + k) * 8 +: 8] = lane_out_s[k];
        end
    end

    // Control FSM, iteration counter and working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wr_r    <= '0;
            mode_r  <= MODE_ENC;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        wr_r    <= in_data;
                        mode_r  <= load_mode_s;
                        cnt_r   <= '0;
                        state_r <= ST_BUSY;
                    end else if ((state_r == ST_DONE) && out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BUSY: begin
                    wr_r <= wr_next_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: GF(2^8)-derived S-box model, per-cycle compare, directed and random stimulus.
module tb_sub_bytes_iter;

    localparam int NUM_BYTES = 16;
    parameter  int LANES     = 4;
    localparam int ITERS     = NUM_BYTES / LANES;
    localparam int DW        = 8 * NUM_BYTES;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_mode;
    logic [DW-1:0] out_data;
    logic          busy;

    sub_bytes_iter #(.NUM_BYTES(NUM_BYTES), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    always @(negedge clk) if (busy === 1'b1) busy_cnt++;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            m_fwd[x] = s;
            m_inv[s] = 8'(x);
        end
    endtask

    function automatic logic eff_mode(input logic m);
`ifdef SUBBYTES_INV_EN
        return m;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] model_sub(input logic [DW-1:0] d, input logic m);
        logic [DW-1:0] r;
        for (int i = 0; i < NUM_BYTES; i++)
            r[8*i +: 8] = eff_mode(m) ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
        return r;
    endfunction

    // Reference: a block accepted at edge t is present from edge t+ITERS until consumed.
    bit            mon_en   = 1'b0;
    int            m_remain = 0;
    bit            m_res    = 1'b0;
    logic [DW-1:0] m_pend, m_out;
    logic          m_pmode, m_omode;

    always @(negedge clk) begin
        logic exp_ready;
        if (mon_en) begin
            exp_ready = (m_remain == 0) && (!m_res || out_ready);
            check("in_ready", DW'(in_ready), DW'(exp_ready));
            check("out_valid", DW'(out_valid), DW'(m_res));
            check("busy", DW'(busy), DW'(m_remain > 0));
            if (m_res) begin
                check("out_data", out_data, m_out);
                check("out_mode", DW'(out_mode), DW'(m_omode));
            end
            if (rst) begin
                m_remain = 0;
                m_res    = 1'b0;
            end else begin
                if (m_res && out_ready) m_res = 1'b0;
                if (m_remain > 0) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_res   = 1'b1;
                        m_out   = m_pend;
                        m_omode = m_pmode;
                    end
                end
                if (in_valid && exp_ready) begin
                    m_pend   = model_sub(in_data, in_mode);
                    m_pmode  = eff_mode(in_mode);
                    m_remain = ITERS;
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input logic m, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_mode = m;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) check("send_timeout", DW'(0), DW'(1));
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = {4{$urandom}};
        in_mode  = 1'($urandom);
    endtask

    task automatic wait_out(output logic [DW-1:0] d, output logic m, output int at);
        bit ok;
        ok = 1'b0; at = -1; d = '0; m = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1; at = cyc; d = out_data; m = out_mode;
            end
        end
        if (!ok) check("out_timeout", DW'(0), DW'(1));
    endtask

    logic [DW-1:0] fips_in, fips_out, d, d0, r;
    logic          m;
    int            acc, at;
    int            acc_list [$];

    initial begin
        fips_in  = {8'h08, 8'h48, 8'hf8, 8'he9, 8'h2a, 8'h8d, 8'hc6, 8'h9a,
                    8'h2b, 8'he2, 8'hf4, 8'ha0, 8'hbe, 8'he3, 8'h3d, 8'h19};
        fips_out = {8'h30, 8'h52, 8'h41, 8'h1e, 8'he5, 8'h5d, 8'hb4, 8'hb8,
                    8'hf1, 8'h98, 8'hbf, 8'he0, 8'hae, 8'h11, 8'h27, 8'hd4};
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;

        build_tables();
        check("model_S00", DW'(m_fwd[0]),   DW'(8'h63));
        check("model_S53", DW'(m_fwd[83]),  DW'(8'hed));
        check("model_SFF", DW'(m_fwd[255]), DW'(8'h16));
        check("model_I00", DW'(m_inv[0]),   DW'(8'h52));
        check("model_I63", DW'(m_inv[99]),  DW'(8'h00));
        check("model_IED", DW'(m_inv[237]), DW'(8'h53));

        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_mode", DW'(out_mode), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Test 1: all-zero block, busy for exactly ITERS cycles.
        busy_cnt = 0;
        send('0, 1'b0, acc);
        wait_out(d, m, at);
        check("t1_latency", DW'(at - acc), DW'(ITERS));
        check("t1_data", d, {NUM_BYTES{8'h63}});
        check("t1_busy_cycles", DW'(busy_cnt), DW'(ITERS));

        // Test 2/3: FIPS-197 round-1 vector, forward then back.
        @(posedge clk); #1;
        send(fips_in, 1'b0, acc);
        wait_out(d, m, at);
        check("t2_data", d, fips_out);
        check("t2_mode", DW'(m), DW'(0));
        @(posedge clk); #1;
        send(fips_out, 1'b1, acc);
        wait_out(d, m, at);
`ifdef SUBBYTES_INV_EN
        check("t3_data", d, fips_in);
        check("t3_mode", DW'(m), DW'(1));
`else
        check("t3_data", d, model_sub(fips_out, 1'b0));
        check("t3_mode", DW'(m), DW'(0));
`endif

        // Test 4: backpressure, then release together with a new accept.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send({4{$urandom}}, 1'($urandom), acc);
        wait_out(d0, m, at);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_data", out_data, d0);
            check("t4_hold_ready", DW'(in_ready), DW'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        r = {4{$urandom}};
        send(r, 1'b0, acc);
        wait_out(d, m, at);
        check("t4_latency", DW'(at - acc), DW'(ITERS));
        check("t4_data", d, model_sub(r, 1'b0));

        // Test 5: reset in the middle of BUSY.
        @(posedge clk); #1;
        send({4{$urandom}}, 1'($urandom), acc);
        for (int i = 0; i < ((ITERS > 2) ? 2 : ITERS - 1); i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_out_data", out_data, '0);
        check("t5_out_mode", DW'(out_mode), DW'(0));
        check("t5_in_ready", DW'(in_ready), DW'(1));
        for (int i = 0; i < ITERS + 3; i++) begin
            @(negedge clk);
            check("t5_no_valid", DW'(out_valid), DW'(0));
        end

        // Test 6: every byte value in both modes, with exact latency.
        for (int md = 0; md < 2; md++) begin
            for (int j = 0; j < 256 / NUM_BYTES; j++) begin
                for (int i = 0; i < NUM_BYTES; i++) r[8*i +: 8] = 8'(j * NUM_BYTES + i);
                @(posedge clk); #1;
                send(r, 1'(md), acc);
                wait_out(d, m, at);
                check("t6_latency", DW'(at - acc), DW'(ITERS));
            end
        end

        // Back-to-back: continuous valid with ready downstream accepts every ITERS+1 cycles.
        @(posedge clk); #1;
        in_valid = 1'b1;
        acc_list.delete();
        for (int i = 0; i < 6 * (ITERS + 1); i++) begin
            in_data = {4{$urandom}}; in_mode = 1'($urandom);
            @(negedge clk);
            if (in_ready === 1'b1) acc_list.push_back(cyc);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("b2b_count", DW'(acc_list.size() >= 5), DW'(1));
        for (int i = 1; i < acc_list.size(); i++)
            check("b2b_spacing", DW'(acc_list[i] - acc_list[i-1]), DW'(ITERS + 1));

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            in_data   = {4{$urandom}};
            in_mode   = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (ITERS + 4) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
